// File: rtl/div_lut_pkg.sv
// Shared widths, pipeline latency and reciprocal-table entry function for the
// LUT-based fixed-point divider.
package div_lut_pkg;

  localparam int unsigned NB_DATA_IN_DEF  = 8;
  localparam int unsigned NB_DATA_OUT_DEF = 8;
  localparam int unsigned NB_FRAC_DEF     = 4;
  localparam int unsigned NB_LUT_ADDR_DEF = 5;
  localparam int unsigned DIV_LUT_LATENCY = 4;

  // Per-stage control bits that travel alongside the datapath
  typedef struct packed {
    logic valid;
    logic neg;      // result sign
    logic div0;     // denominator was zero
    logic num_z;    // numerator was zero
    logic num_neg;  // numerator sign, picks the div-by-zero rail
  } div_ctl_t;

  // round(2^(nb_out+1) / (1 + k/2^nb_addr)) in integer arithmetic
  function automatic int unsigned recip_entry(input int unsigned k,
                                              input int unsigned nb_out,
                                              input int unsigned nb_addr);
    int unsigned den;
    den = (32'd1 << nb_addr) + k;
    return ((32'd1 << (nb_out + 1 + nb_addr)) + den / 2) / den;
  endfunction

endpackage

// File: rtl/div_lut_pipe_if.sv
// Operand/result handshake bundle for div_lut_pipe.
interface div_lut_pipe_if
  import div_lut_pkg::*;
#(
  parameter int unsigned NB_DATA_IN  = NB_DATA_IN_DEF,
  parameter int unsigned NB_DATA_OUT = NB_DATA_OUT_DEF
);
  logic                   i_valid;
  logic                   o_ready;
  logic [NB_DATA_IN-1:0]  i_num;
  logic [NB_DATA_IN-1:0]  i_den;
  logic                   o_valid;
  logic                   i_ready;
  logic [NB_DATA_OUT-1:0] o_div;
  logic                   o_div0;
  logic                   o_sat;

  modport master (
    output i_valid, i_num, i_den, i_ready,
    input  o_ready, o_valid, o_div, o_div0, o_sat
  );

  modport slave (
    input  i_valid, i_num, i_den, i_ready,
    output o_ready, o_valid, o_div, o_div0, o_sat
  );
endinterface

// File: rtl/div_lut_pipe_recip_rom.sv
// Reciprocal ROM: constant table built at elaboration, one-cycle registered read.
module recip_rom
  import div_lut_pkg::*;
#(
  parameter int unsigned NB_LUT_ADDR = NB_LUT_ADDR_DEF,
  parameter int unsigned NB_DATA_OUT = NB_DATA_OUT_DEF,
  parameter int unsigned NB_REC      = NB_DATA_OUT + 2
) (
  input  logic                   clock,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [NB_LUT_ADDR-1:0] i_addr,
  output logic [NB_REC-1:0]      o_data
);
  localparam int unsigned DEPTH = 32'd1 << NB_LUT_ADDR;

  logic [NB_REC-1:0] table_c [DEPTH];

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_entry
    assign table_c[g] = NB_REC'(recip_entry(32'(g), NB_DATA_OUT, NB_LUT_ADDR));
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n)  o_data <= '0;
    else if (i_en) o_data <= table_c[i_addr];
  end
endmodule

// File: rtl/div_lut_pipe.sv
// 4-stage signed fixed-point divider using a normalized reciprocal ROM.
// DIV_LUT_PIPE_ROUND_EN selects round-to-nearest (ties away) instead of truncation.
module div_lut_pipe
  import div_lut_pkg::*;
#(
  parameter int unsigned NB_DATA_IN  = NB_DATA_IN_DEF,
  parameter int unsigned NB_DATA_OUT = NB_DATA_OUT_DEF,
  parameter int unsigned NB_FRAC     = NB_FRAC_DEF,
  parameter int unsigned NB_LUT_ADDR = NB_LUT_ADDR_DEF
) (
  input logic           clock,
  input logic           i_rst_n,
  div_lut_pipe_if.slave bus
);
  localparam int unsigned NB_REC  = NB_DATA_OUT + 2;
  localparam int unsigned NB_POS  = $clog2(NB_DATA_IN);
  localparam int unsigned NB_PROD = NB_DATA_IN + NB_REC;
  localparam int unsigned NB_SH   = $clog2(NB_DATA_IN + NB_DATA_OUT + 1);
  localparam int unsigned SH_BASE = NB_DATA_OUT + 1 - NB_FRAC;

  localparam logic [NB_DATA_OUT-1:0] Q_MAX   = {1'b0, {(NB_DATA_OUT-1){1'b1}}};
  localparam logic [NB_DATA_OUT-1:0] Q_MIN   = {1'b1, {(NB_DATA_OUT-1){1'b0}}};
  localparam logic [NB_PROD-1:0]     LIM_POS = NB_PROD'(Q_MAX);
  localparam logic [NB_PROD-1:0]     LIM_NEG = NB_PROD'(Q_MIN);

  logic stall;
  assign stall       = bus.o_valid & ~bus.i_ready;
  assign bus.o_ready = ~stall;

  // S1: sign, magnitude, zero detect, leading-one normalize of |den|
  logic                   num_neg_c, den_neg_c;
  logic [NB_DATA_IN-1:0]  mag_n_c, mag_d_c, norm_c;
  logic [NB_POS-1:0]      pos_c;
  logic [NB_LUT_ADDR-1:0] k_c;

  always_comb begin
    num_neg_c = bus.i_num[NB_DATA_IN-1];
    den_neg_c = bus.i_den[NB_DATA_IN-1];
    mag_n_c   = num_neg_c ? (~bus.i_num + 1'b1) : bus.i_num;
    mag_d_c   = den_neg_c ? (~bus.i_den + 1'b1) : bus.i_den;
    pos_c     = '0;
    for (int i = 0; i < int'(NB_DATA_IN); i++) begin
      if (mag_d_c[i]) pos_c = NB_POS'(i);
    end
    norm_c = mag_d_c << (NB_POS'(NB_DATA_IN - 1) - pos_c);
    // Mantissa bits just below the leading one address the ROM
    k_c    = NB_LUT_ADDR'({norm_c, {NB_LUT_ADDR{1'b0}}} >> (NB_DATA_IN - 1));
  end

  div_ctl_t               ctl1, ctl2, ctl3;
  logic [NB_DATA_IN-1:0]  mag_n1, mag_n2;
  logic [NB_POS-1:0]      pos1, pos2, pos3;
  logic [NB_LUT_ADDR-1:0] k1;
  logic [NB_REC-1:0]      rec2;
  logic [NB_PROD-1:0]     prod3;

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctl1   <= '0;
      ctl2   <= '0;
      ctl3   <= '0;
      mag_n1 <= '0;
      mag_n2 <= '0;
      pos1   <= '0;
      pos2   <= '0;
      pos3   <= '0;
      k1     <= '0;
      prod3  <= '0;
    end else if (!stall) begin
      ctl1.valid   <= bus.i_valid;
      ctl1.neg     <= num_neg_c ^ den_neg_c;
      ctl1.div0    <= (mag_d_c == '0);
      ctl1.num_z   <= (mag_n_c == '0);
      ctl1.num_neg <= num_neg_c;
      mag_n1       <= mag_n_c;
      pos1         <= pos_c;
      k1           <= k_c;
      ctl2         <= ctl1;
      mag_n2       <= mag_n1;
      pos2         <= pos1;
      ctl3         <= ctl2;
      prod3        <= NB_PROD'(mag_n2) * NB_PROD'(rec2);
      pos3         <= pos2;
    end
  end

  // S2: reciprocal lookup
  recip_rom #(
    .NB_LUT_ADDR (NB_LUT_ADDR),
    .NB_DATA_OUT (NB_DATA_OUT),
    .NB_REC      (NB_REC)
  ) u_recip_rom (
    .clock   (clock),
    .i_rst_n (i_rst_n),
    .i_en    (~stall),
    .i_addr  (k1),
    .o_data  (rec2)
  );

  // S4: denormalize, round/truncate, saturate, apply sign
  logic [NB_SH-1:0]       sh_c;
  logic [NB_PROD-1:0]     mag_q_c;
  logic [NB_DATA_OUT-1:0] div_c;
  logic                   sat_c;

  always_comb begin
    sh_c  = NB_SH'(SH_BASE) + NB_SH'(pos3);
`ifdef DIV_LUT_PIPE_ROUND_EN
    mag_q_c = (prod3 >> sh_c) + NB_PROD'(prod3[sh_c - NB_SH'(1)]);
`else
    mag_q_c = prod3 >> sh_c;
`endif
    div_c = '0;
    sat_c = 1'b0;
    if (ctl3.div0) begin
      if (!ctl3.num_z) div_c = ctl3.num_neg ? Q_MIN : Q_MAX;
    end else if (ctl3.num_z) begin
      div_c = '0;
    end else if (ctl3.neg) begin
      if (mag_q_c > LIM_NEG) begin
        div_c = Q_MIN;
        sat_c = 1'b1;
      end else begin
        div_c = ~NB_DATA_OUT'(mag_q_c) + 1'b1;
      end
    end else begin
      if (mag_q_c > LIM_POS) begin
        div_c = Q_MAX;
        sat_c = 1'b1;
      end else begin
        div_c = NB_DATA_OUT'(mag_q_c);
      end
    end
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_div   <= '0;
      bus.o_div0  <= 1'b0;
      bus.o_sat   <= 1'b0;
    end else if (!stall) begin
      bus.o_valid <= ctl3.valid;
      bus.o_div   <= div_c;
      bus.o_div0  <= ctl3.div0;
      bus.o_sat   <= sat_c;
    end
  end
endmodule

// File: tb/tb_div_lut_pipe.sv
// Directed self-checking bench for div_lut_pipe (default parameters).
module tb_div_lut_pipe;
  import div_lut_pkg::*;

  logic clock = 1'b0;
  logic i_rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  div_lut_pipe_if #(.NB_DATA_IN(8), .NB_DATA_OUT(8)) bus ();

  div_lut_pipe dut (
    .clock   (clock),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single operand pair through an idle pipe; checks latency and all result fields
  task automatic run_op(input string tag, input int num, input int den,
                        input logic [7:0] q_trunc, input logic [7:0] q_round,
                        input logic div0, input logic sat);
    logic [7:0] q_exp;
    int cyc;
`ifdef DIV_LUT_PIPE_ROUND_EN
    q_exp = q_round;
`else
    q_exp = q_trunc;
`endif
    @(negedge clock);
    bus.i_num   = 8'(num);
    bus.i_den   = 8'(den);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      bus.i_valid = 1'b0;
      cyc++;
    end while (!bus.o_valid && cyc < 10);
    check_eq({tag, "_lat"},  32'(cyc), DIV_LUT_LATENCY);
    check_eq({tag, "_div"},  32'(bus.o_div), 32'(q_exp));
    check_eq({tag, "_div0"}, 32'(bus.o_div0), 32'(div0));
    check_eq({tag, "_sat"},  32'(bus.o_sat), 32'(sat));
  endtask

  // Eight back-to-back pairs (n/2), downstream stalls during cycles 6..8
  task automatic stream_test();
    int sent = 0;
    int got  = 0;
    int c    = 0;
    @(negedge clock);
    while (got < 8 && c < 60) begin
      bus.i_ready = !(c >= 6 && c < 9);
      bus.i_valid = (sent < 8);
      bus.i_num   = 8'(sent + 1);
      bus.i_den   = 8'd2;
      #1;
      check_eq("st_rdy", 32'(bus.o_ready), (c >= 6 && c < 9) ? 32'd0 : 32'd1);
      if (bus.o_valid) begin
        check_eq("st_div", 32'(bus.o_div), 32'((got + 1) * 8));
        if (bus.i_ready) got++;
      end
      if (bus.i_valid && bus.o_ready) sent++;
      @(negedge clock);
      c++;
    end
    check_eq("st_cnt", 32'(got), 32'd8);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check_eq("st_extra", 32'(bus.o_valid), 32'd0);
    end
  endtask

  // Reset with the pipe full; no stale result may surface afterwards
  task automatic reset_test();
    @(negedge clock);
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_den   = 8'd1;
    for (int i = 0; i < 4; i++) begin
      bus.i_num = 8'(i + 1);
      @(negedge clock);
    end
    check_eq("rst_pre_valid", 32'(bus.o_valid), 32'd1);
    i_rst_n     = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bus.o_valid), 32'd0);
    check_eq("rst_div",   32'(bus.o_div),   32'd0);
    check_eq("rst_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clock);
    i_rst_n = 1'b1;
    repeat (8) begin
      @(negedge clock);
      check_eq("rst_stale", 32'(bus.o_valid), 32'd0);
    end
    run_op("post_rst", 3, 2, 8'h18, 8'h18, 1'b0, 1'b0);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_num   = '0;
    bus.i_den   = '0;
    i_rst_n     = 1'b0;
    #1;
    check_eq("reset_valid", 32'(bus.o_valid), 32'd0);
    check_eq("reset_ready", 32'(bus.o_ready), 32'd1);
    check_eq("reset_div",   32'(bus.o_div),   32'd0);
    check_eq("reset_flags", 32'({bus.o_div0, bus.o_sat}), 32'd0);
    repeat (2) @(negedge clock);
    i_rst_n = 1'b1;

    //      tag          num   den  trunc  round  div0  sat
    run_op("p3_d2",       3,    2, 8'h18, 8'h18, 1'b0, 1'b0);
    run_op("m6_d2",      -6,    2, 8'hD0, 8'hD0, 1'b0, 1'b0);
    run_op("sat_pos",   100,    1, 8'h7F, 8'h7F, 1'b0, 1'b1);
    run_op("sat_neg",  -128,    1, 8'h80, 8'h80, 1'b0, 1'b1);
    run_op("d0_pos",      5,    0, 8'h7F, 8'h7F, 1'b1, 1'b0);
    run_op("d0_neg",     -5,    0, 8'h80, 8'h80, 1'b1, 1'b0);
    run_op("d0_zero",     0,    0, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("num0",        0,    7, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("p1_d3",       1,    3, 8'h05, 8'h05, 1'b0, 1'b0);
    run_op("p7_d3",       7,    3, 8'h25, 8'h25, 1'b0, 1'b0);
    run_op("p2_d3",       2,    3, 8'h0A, 8'h0B, 1'b0, 1'b0);
    run_op("m2_d3",      -2,    3, 8'hF6, 8'hF5, 1'b0, 1'b0);
    run_op("m128_m128", -128, -128, 8'h10, 8'h10, 1'b0, 1'b0);
    run_op("p127_m128",  127, -128, 8'hF1, 8'hF0, 1'b0, 1'b0);
    run_op("p20_d4",     20,    4, 8'h50, 8'h50, 1'b0, 1'b0);
    run_op("m20_m4",    -20,   -4, 8'h50, 8'h50, 1'b0, 1'b0);
    run_op("p8_d1",       8,    1, 8'h7F, 8'h7F, 1'b0, 1'b1);
    run_op("m8_d1",      -8,    1, 8'h80, 8'h80, 1'b0, 1'b0);
    run_op("m1_d127",    -1,  127, 8'h00, 8'h00, 1'b0, 1'b0);

    stream_test();
    reset_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
